// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
package spi_pkg;

    // Transfer phases; every phase except IDLE lasts exactly CLK_DIV cycles.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } spi_state_t;

    localparam int         SPI_MAX_BITS  = 32;
    localparam logic [5:0] SPI_NBITS_MAX = 6'd31;

    // Longest transfer is SPI_MAX_BITS bits, so the length-minus-one field saturates at 31.
    function automatic logic [4:0] clamp_nbits(input logic [5:0] nbits);
        logic [4:0] result;
        if (nbits > SPI_NBITS_MAX) begin
            result = 5'd31;
        end else begin
            result = nbits[4:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_tick.sv
// Phase timer: strobes phase_end on the last cycle of each CLK_DIV-cycle phase.
module spi_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic restart,
    output logic phase_end
);

    localparam int             CW     = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  ONE    = CW'(1);

    logic [CW-1:0] cnt_reg;

    // Reload on every phase change so the new phase ends CLK_DIV cycles later.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_reg <= RELOAD;
        end else if (restart) begin
            cnt_reg <= RELOAD;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - ONE;
        end
    end

    assign phase_end = (cnt_reg == '0);

endmodule

// File: rtl/spi_master.sv
// SPI mode-3 master: shifts out up to 32 bits MSB-first and returns MISO right-justified.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [31:0] spi_mosi_data,
    input  logic [5:0]  spi_nbits,
    input  logic        spi_request,
    output logic [31:0] spi_miso_data,
    output logic        spi_ready,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    spi_state_t  state_reg;
    logic [31:0] shift_tx_reg;
    logic [31:0] shift_rx_reg;
    logic [4:0]  bit_cnt_reg;
    logic [31:0] miso_data_reg;
    logic        ready_reg;
    logic        sclk_reg;
    logic        mosi_reg;
    logic        cs_n_reg;

    logic        phase_end;
    logic        restart;
    logic [4:0]  req_bits;
    logic [4:0]  next_bit;

    // Every non-idle phase ends on the timer strobe; leaving IDLE happens on an accepted request.
    assign restart  = (state_reg == IDLE) ? spi_request : phase_end;
    assign req_bits = clamp_nbits(spi_nbits);
    assign next_bit = bit_cnt_reg - 5'd1;

    spi_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk_in   (clk_in),
        .rst      (rst),
        .restart  (restart),
        .phase_end(phase_end)
    );

    // Transfer sequencer with registered pin and result outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_reg     <= IDLE;
            shift_tx_reg  <= '0;
            shift_rx_reg  <= '0;
            bit_cnt_reg   <= '0;
            miso_data_reg <= '0;
            ready_reg     <= 1'b0;
            sclk_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
            cs_n_reg      <= 1'b1;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    sclk_reg <= 1'b1;
                    cs_n_reg <= 1'b1;
                    if (spi_request) begin
                        shift_tx_reg <= spi_mosi_data;
                        bit_cnt_reg  <= req_bits;
                        shift_rx_reg <= '0;
                        cs_n_reg     <= 1'b0;
                        mosi_reg     <= spi_mosi_data[req_bits];
                        state_reg    <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        sclk_reg  <= 1'b0;
                        state_reg <= LOW;
                    end
                end
                LOW: begin
                    // Rising SCLK: capture MISO as it stands at this clk_in edge.
                    if (phase_end) begin
                        sclk_reg     <= 1'b1;
                        shift_rx_reg <= {shift_rx_reg[30:0], spi_miso};
                        state_reg    <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        if (bit_cnt_reg != 5'd0) begin
                            // Falling SCLK: present the next MOSI bit.
                            bit_cnt_reg <= next_bit;
                            mosi_reg    <= shift_tx_reg[next_bit];
                            sclk_reg    <= 1'b0;
                            state_reg   <= LOW;
                        end else begin
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        cs_n_reg  <= 1'b1;
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (phase_end) begin
                        miso_data_reg <= shift_rx_reg;
                        ready_reg     <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign spi_miso_data = miso_data_reg;
    assign spi_ready     = ready_reg;
    assign spi_sclk      = sclk_reg;
    assign spi_mosi      = mosi_reg;
    assign spi_cs_n      = cs_n_reg;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: instance 0 runs CLK_DIV=4, instance 1 runs CLK_DIV=1.
module tb_spi_master;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst        [2];
    logic        req        [2];
    logic [31:0] mosi_data  [2];
    logic [5:0]  nbits      [2];
    logic        miso_line  [2];
    logic [31:0] miso_data  [2];
    logic        ready      [2];
    logic        sclk       [2];
    logic        mosi       [2];
    logic        cs_n       [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        spi_master #(
            .CLK_DIV(gi == 0 ? 4 : 1)
        ) dut (
            .clk_in       (clk_in),
            .rst          (rst[gi]),
            .spi_mosi_data(mosi_data[gi]),
            .spi_nbits    (nbits[gi]),
            .spi_request  (req[gi]),
            .spi_miso_data(miso_data[gi]),
            .spi_ready    (ready[gi]),
            .spi_sclk     (sclk[gi]),
            .spi_mosi     (mosi[gi]),
            .spi_miso     (miso_line[gi]),
            .spi_cs_n     (cs_n[gi])
        );
    end

    typedef struct {
        logic [31:0] miso;
        logic [31:0] mosi;
        int          rises;
        int          cs_low;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] slave_word [2];
    int          slave_n    [2];
    logic        done = 1'b0;

    int check_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp_v);
        check_cnt++;
        if (act === exp_v) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s (inst %0d): got 0x%08h, expected 0x%08h", name, inst, act, exp_v);
        end
    endtask

    // Monitor + slave model: owns the scoreboard pops and all checking.
    initial begin : monitor
        int          cyc;
        int          pend_age;
        int          e0      [2];
        int          cs_low  [2];
        int          rises   [2];
        int          sidx    [2];
        logic [31:0] mosi_cap[2];
        logic        prev_sclk[2];
        logic        prev_cs [2];
        logic        rst_edge[2];
        logic        final_done;
        exp_t        e;
        cyc = 0;
        pend_age = 0;
        final_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e0[i] = 0; cs_low[i] = 0; rises[i] = 0; sidx[i] = 0;
            mosi_cap[i] = '0; prev_sclk[i] = 1'b1; prev_cs[i] = 1'b1;
            miso_line[i] = 1'b0;
        end
        forever begin
            @(posedge clk_in);
            for (int i = 0; i < 2; i++) rst_edge[i] = rst[i];
            #1;
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (rst_edge[i]) begin
                    chk("reset_pins_cs_sclk_mosi_ready", i,
                        {28'd0, cs_n[i], sclk[i], mosi[i], ready[i]}, 32'h0000_000C);
                    chk("reset_miso_data", i, miso_data[i], 32'h0);
                end
                if (prev_cs[i] && !cs_n[i]) begin
                    e0[i] = cyc; cs_low[i] = 0; rises[i] = 0;
                    mosi_cap[i] = '0; sidx[i] = slave_n[i] - 1;
                end
                if (!cs_n[i]) cs_low[i]++;
                if (!cs_n[i] && !prev_sclk[i] && sclk[i]) begin
                    mosi_cap[i] = {mosi_cap[i][30:0], mosi[i]};
                    rises[i]++;
                end
                if (!cs_n[i] && prev_sclk[i] && !sclk[i]) begin
                    if (sidx[i] >= 0) miso_line[i] = slave_word[i][sidx[i]];
                    sidx[i]--;
                end
                if (ready[i]) begin
                    if (exp_q.size() == 0) begin
                        chk("ready_unexpected", i, {31'd0, ready[i]}, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        pend_age = 0;
                        chk("miso_data", i, miso_data[i], e.miso);
                        chk("mosi_bits", i, mosi_cap[i], e.mosi);
                        chk("sclk_rises", i, 32'(rises[i]), 32'(e.rises));
                        chk("cs_low_cycles", i, 32'(cs_low[i]), 32'(e.cs_low));
                        chk("ready_latency", i, 32'(cyc - e0[i]), 32'(e.lat));
                    end
                end
                prev_cs[i]   = cs_n[i];
                prev_sclk[i] = sclk[i];
            end
            if (exp_q.size() != 0) begin
                pend_age++;
                if (pend_age > 2000) begin
                    check_cnt++;
                    $display("FAIL ready_timeout: no ready after %0d cycles, required within 2000", pend_age);
                    void'(exp_q.pop_front());
                    pend_age = 0;
                end
            end
            if (done && !final_done) begin
                chk("pending_at_end", 0, 32'(exp_q.size()), 32'h0);
                final_done = 1'b1;
            end
        end
    end

    task automatic push_exp(input logic [31:0] m_miso, input logic [31:0] m_mosi,
                            input int m_rises, input int m_cs, input int m_lat);
        exp_t e;
        e.miso = m_miso; e.mosi = m_mosi; e.rises = m_rises; e.cs_low = m_cs; e.lat = m_lat;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; issues a one-cycle request.
    task automatic start(input int i, input logic [5:0] nb, input logic [31:0] d,
                         input logic [31:0] sw, input int sn);
        slave_word[i] = sw;
        slave_n[i]    = sn;
        nbits[i]      = nb;
        mosi_data[i]  = d;
        req[i]        = 1'b1;
        @(negedge clk_in);
        req[i]        = 1'b0;
    endtask

    task automatic pulse_req(input int i, input logic [31:0] d);
        mosi_data[i] = d;
        req[i]       = 1'b1;
        @(negedge clk_in);
        req[i]       = 1'b0;
    endtask

    task automatic wait_ready(input int i);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_in);
            if (ready[i]) return;
        end
    endtask

    // Directed stimulus; expectations are hand-computed: cs low (2n+2)D, ready (2n+3)D after E0.
    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; mosi_data[i] = '0; nbits[i] = '0;
            slave_word[i] = '0; slave_n[i] = 1;
        end
        repeat (2) @(negedge clk_in);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk_in);

        // WHO_AM_I read, 16 bits
        push_exp(32'h0000_0033, 32'h0000_8F00, 16, 136, 140);
        start(0, 6'd15, 32'h0000_8F00, 32'h0000_0033, 16);
        wait_ready(0);
        repeat (3) @(negedge clk_in);

        // POWER_CTL write, 24 bits
        push_exp(32'h005A_5A5A, 32'h000A_2D02, 24, 200, 204);
        start(0, 6'd23, 32'h000A_2D02, 32'h005A_5A5A, 24);
        wait_ready(0);
        repeat (3) @(negedge clk_in);

        // Requests while busy are ignored; a request right after ready is accepted
        push_exp(32'h0000_BEEF, 32'h0000_1234, 16, 136, 140);
        start(0, 6'd15, 32'h0000_1234, 32'h0000_BEEF, 16);
        repeat (8) @(negedge clk_in);
        pulse_req(0, 32'h0000_FFFF);
        repeat (39) @(negedge clk_in);
        pulse_req(0, 32'h0000_0000);
        mosi_data[0] = 32'h0000_1234;
        wait_ready(0);
        @(negedge clk_in);
        push_exp(32'h0000_0F0F, 32'h0000_5AA5, 16, 136, 140);
        start(0, 6'd15, 32'h0000_5AA5, 32'h0000_0F0F, 16);
        wait_ready(0);
        repeat (3) @(negedge clk_in);

        // Reset mid-transfer around bit 7, then a normal transfer
        start(0, 6'd15, 32'h0000_ABCD, 32'h0000_1111, 16);
        repeat (62) @(negedge clk_in);
        rst[0] = 1'b1;
        @(negedge clk_in);
        rst[0] = 1'b0;
        repeat (5) @(negedge clk_in);
        push_exp(32'h0000_9999, 32'h0000_C3C3, 16, 136, 140);
        start(0, 6'd15, 32'h0000_C3C3, 32'h0000_9999, 16);
        wait_ready(0);
        repeat (3) @(negedge clk_in);

        // Single-bit transfer
        push_exp(32'h0000_0001, 32'h0000_0001, 1, 16, 20);
        start(0, 6'd0, 32'h0000_0001, 32'h0000_0001, 1);
        wait_ready(0);
        repeat (3) @(negedge clk_in);

        // Length clamp: nbits=40 runs 32 bits
        push_exp(32'hA5C3_0F96, 32'hDEAD_BEEF, 32, 264, 268);
        start(0, 6'd40, 32'hDEAD_BEEF, 32'hA5C3_0F96, 32);
        wait_ready(0);
        repeat (3) @(negedge clk_in);

        // CLK_DIV=1, 8 bits
        push_exp(32'h0000_003C, 32'h0000_00C5, 8, 18, 19);
        start(1, 6'd7, 32'h0000_00C5, 32'h0000_003C, 8);
        wait_ready(1);
        repeat (3) @(negedge clk_in);

        done = 1'b1;
        repeat (3) @(negedge clk_in);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
